// File: rtl/fp_issue_ctrl.sv
// Issue-side controller for the combinational FP unit: decodes one F/D op per handshake,
// holds FPU controls for a fixed latency window, then presents the captured result to writeback.
// Optional: define FPU_FAST_PATH_EN to run minmax/cmp/sgnj with a single EXEC cycle.
module fp_issue_ctrl #(
    parameter int DATA_WIDTH  = 64,
    parameter int LAT_DEFAULT = 2,
    parameter int LAT_DIV     = 8,
    parameter int CNT_W       = 4
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_valid,
    output logic                  out_ready,
    input  logic [6:0]            in_funct7,
    input  logic [2:0]            in_funct3,
    input  logic [4:0]            in_rs2_sel,
    input  logic [DATA_WIDTH-1:0] in_rs1_data,
    input  logic [DATA_WIDTH-1:0] in_rs2_data,
    output logic [DATA_WIDTH-1:0] out_fpu_rs1,
    output logic [DATA_WIDTH-1:0] out_fpu_rs2,
    output logic [3:0]            out_FPU_Op,
    output logic                  out_fmt,
    output logic                  out_output_fmt,
    output logic                  out_addsub_ctrl,
    output logic [2:0]            out_ctrl,
    input  logic [DATA_WIDTH-1:0] in_fpu_result,
    output logic                  out_valid,
    input  logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_illegal,
    output logic                  out_busy
);

    localparam logic [4:0] CLS_ADD    = 5'b00000;
    localparam logic [4:0] CLS_SUB    = 5'b00001;
    localparam logic [4:0] CLS_MUL    = 5'b00010;
    localparam logic [4:0] CLS_DIV    = 5'b00011;
    localparam logic [4:0] CLS_SGNJ   = 5'b00100;
    localparam logic [4:0] CLS_MINMAX = 5'b00101;
    localparam logic [4:0] CLS_CVT_FF = 5'b01000;
    localparam logic [4:0] CLS_CMP    = 5'b10100;
    localparam logic [4:0] CLS_CVT_FI = 5'b11000;

    localparam logic [3:0] OP_ADDSUB = 4'd0;
    localparam logic [3:0] OP_MUL    = 4'd1;
    localparam logic [3:0] OP_DIV    = 4'd2;
    localparam logic [3:0] OP_MINMAX = 4'd3;
    localparam logic [3:0] OP_CMP    = 4'd4;
    localparam logic [3:0] OP_SGNJ   = 4'd5;
    localparam logic [3:0] OP_CVT_FF = 4'd6;
    localparam logic [3:0] OP_CVT_FI = 4'd7;
    localparam logic [3:0] OP_NONE   = 4'hF;

    // Counter load values are latency minus one: the final EXEC cycle is the capture cycle.
    localparam logic [CNT_W-1:0] LD_DEFAULT = CNT_W'(LAT_DEFAULT - 1);
    localparam logic [CNT_W-1:0] LD_DIV     = CNT_W'(LAT_DIV - 1);
`ifdef FPU_FAST_PATH_EN
    localparam logic [CNT_W-1:0] LD_SIMPLE  = '0;
`else
    localparam logic [CNT_W-1:0] LD_SIMPLE  = CNT_W'(LAT_DEFAULT - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             capture;

    logic [4:0]       op_class;
    logic [3:0]       dec_op;
    logic             dec_addsub;
    logic             dec_ofmt;
    logic             dec_ill;
    logic [CNT_W-1:0] dec_ld;
    logic [2:0]       dec_ctrl;

    logic             unused_rs2_bits;

    assign op_class        = in_funct7[6:2];
    assign dec_ctrl        = {1'b0, in_funct3[1:0]};
    assign unused_rs2_bits = ^{in_rs2_sel[4:2], in_rs2_sel[0]};

    always_comb begin
        dec_op     = OP_NONE;
        dec_addsub = 1'b0;
        dec_ofmt   = 1'b0;
        dec_ill    = 1'b0;
        dec_ld     = LD_DEFAULT;
        case (op_class)
            CLS_ADD: dec_op = OP_ADDSUB;
            CLS_SUB: begin
                dec_op     = OP_ADDSUB;
                dec_addsub = 1'b1;
            end
            CLS_MUL: dec_op = OP_MUL;
            CLS_DIV: begin
                dec_op = OP_DIV;
                dec_ld = LD_DIV;
            end
            CLS_MINMAX: begin
                dec_op  = OP_MINMAX;
                dec_ld  = LD_SIMPLE;
                dec_ill = (in_funct3[2:1] != 2'b00);
            end
            CLS_CMP: begin
                dec_op  = OP_CMP;
                dec_ld  = LD_SIMPLE;
                dec_ill = (in_funct3[1:0] == 2'b11);
            end
            CLS_SGNJ: begin
                dec_op  = OP_SGNJ;
                dec_ld  = LD_SIMPLE;
                dec_ill = (in_funct3[1:0] == 2'b11);
            end
            CLS_CVT_FF: dec_op = OP_CVT_FF;
            CLS_CVT_FI: begin
                dec_op   = OP_CVT_FI;
                dec_ofmt = in_rs2_sel[1];
            end
            default: dec_ill = 1'b1;
        endcase
        // Only S and D formats exist; fmt[1] set means H/Q, which this unit does not implement.
        if (in_funct7[1]) begin
            dec_ill = 1'b1;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = dec_ill ? S_DONE : S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (in_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign out_ready = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign out_busy  = (state != S_IDLE);

    // Accept stage: controls and operands stay frozen until the next accepted op.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            cnt             <= '0;
            out_fpu_rs1     <= '0;
            out_fpu_rs2     <= '0;
            out_FPU_Op      <= OP_NONE;
            out_fmt         <= 1'b0;
            out_output_fmt  <= 1'b0;
            out_addsub_ctrl <= 1'b0;
            out_ctrl        <= '0;
            out_result      <= '0;
            out_illegal     <= 1'b0;
        end else if (accept) begin
            cnt             <= dec_ld;
            out_fpu_rs1     <= in_rs1_data;
            out_fpu_rs2     <= in_rs2_data;
            out_FPU_Op      <= dec_ill ? OP_NONE : dec_op;
            out_fmt         <= in_funct7[0];
            out_output_fmt  <= dec_ofmt;
            out_addsub_ctrl <= dec_addsub;
            out_ctrl        <= dec_ctrl;
            if (dec_ill) begin
                out_result  <= '0;
                out_illegal <= 1'b1;
            end
        end else if (state == S_EXEC) begin
            // Capture stage: the FPU output has settled once the window has elapsed.
            if (capture) begin
                out_result  <= in_fpu_result;
                out_illegal <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    a_done_hold: assert property (@(posedge in_clk) disable iff (!in_rst_n)
        (state == S_DONE && !in_ready) |=> (out_valid && $stable(out_result)));

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Randomized bench for fp_issue_ctrl against a timestamp-based transaction model,
// plus directed FADD/FDIV/backpressure/illegal/FMAX/reset cases with literal expectations.
module tb_fp_issue_ctrl;
    localparam int DW          = 64;
    localparam int LAT_DEFAULT = 2;
    localparam int LAT_DIV     = 8;
`ifdef FPU_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic          in_clk, in_rst_n, in_valid, out_ready;
    logic [6:0]    in_funct7;
    logic [2:0]    in_funct3;
    logic [4:0]    in_rs2_sel;
    logic [DW-1:0] in_rs1_data, in_rs2_data, out_fpu_rs1, out_fpu_rs2;
    logic [3:0]    out_FPU_Op;
    logic          out_fmt, out_output_fmt, out_addsub_ctrl;
    logic [2:0]    out_ctrl;
    logic [DW-1:0] in_fpu_result, out_result;
    logic          out_valid, in_ready, out_illegal, out_busy;

    fp_issue_ctrl #(.DATA_WIDTH(DW), .LAT_DEFAULT(LAT_DEFAULT), .LAT_DIV(LAT_DIV), .CNT_W(4)) dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_valid(in_valid), .out_ready(out_ready),
        .in_funct7(in_funct7), .in_funct3(in_funct3), .in_rs2_sel(in_rs2_sel),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_fpu_rs1(out_fpu_rs1), .out_fpu_rs2(out_fpu_rs2), .out_FPU_Op(out_FPU_Op),
        .out_fmt(out_fmt), .out_output_fmt(out_output_fmt), .out_addsub_ctrl(out_addsub_ctrl),
        .out_ctrl(out_ctrl), .in_fpu_result(in_fpu_result), .out_valid(out_valid),
        .in_ready(in_ready), .out_result(out_result), .out_illegal(out_illegal), .out_busy(out_busy)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction model: an op is outstanding from its accept edge until the handshake edge;
    // the result becomes visible after edge m_ve (accept edge for illegal, accept+LAT otherwise).
    bit            m_pending;
    int            m_n, m_ve;
    logic [DW-1:0] m_res, m_rs1, m_rs2;
    bit            m_ill, m_fmt, m_ofmt, m_as, m_ctl_ok;
    logic [3:0]    m_op;
    logic [2:0]    m_ctrl;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic decode(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] r2,
                          output logic [3:0] op, output bit as, output bit ofmt, output bit ill);
        op = 4'hF; as = 0; ofmt = 0; ill = 0;
        case (f7[6:2])
            5'd0:  op = 4'd0;
            5'd1:  begin op = 4'd0; as = 1; end
            5'd2:  op = 4'd1;
            5'd3:  op = 4'd2;
            5'd5:  begin op = 4'd3; ill = (f3[2:1] != 2'b00); end
            5'd20: begin op = 4'd4; ill = (f3[1:0] == 2'b11); end
            5'd4:  begin op = 4'd5; ill = (f3[1:0] == 2'b11); end
            5'd8:  op = 4'd6;
            5'd24: begin op = 4'd7; ofmt = r2[1]; end
            default: ill = 1;
        endcase
        if (f7[1]) ill = 1;
    endtask

    function automatic int lat_of(input logic [3:0] op);
        if (op == 4'd2) return LAT_DIV;
        if (FAST && (op == 4'd3 || op == 4'd4 || op == 4'd5)) return 1;
        return LAT_DEFAULT;
    endfunction

    task automatic model_reset();
        m_pending = 0; m_n = 0; m_ve = 0; m_res = '0; m_ill = 0;
        m_op = 4'hF; m_fmt = 0; m_ofmt = 0; m_as = 0; m_ctrl = '0;
        m_rs1 = '0; m_rs2 = '0; m_ctl_ok = 1;
    endtask

    task automatic model_edge();
        logic [3:0] op;
        bit as, ofmt, ill;
        m_n++;
        if (!m_pending) begin
            if (in_valid) begin
                decode(in_funct7, in_funct3, in_rs2_sel, op, as, ofmt, ill);
                m_pending = 1;
                if (ill) begin
                    m_ve = m_n; m_res = '0; m_ill = 1; m_ctl_ok = 0;
                end else begin
                    m_ve = m_n + lat_of(op); m_ctl_ok = 1;
                    m_op = op; m_as = as; m_ofmt = ofmt; m_fmt = in_funct7[0];
                    m_ctrl = {1'b0, in_funct3[1:0]}; m_rs1 = in_rs1_data; m_rs2 = in_rs2_data;
                end
            end
        end else if (m_n == m_ve) begin
            m_res = in_fpu_result; m_ill = 0;
        end else if (m_n > m_ve && in_ready) begin
            m_pending = 0;
        end
    endtask

    task automatic compare();
        bit exp_valid;
        exp_valid = m_pending && (m_n >= m_ve);
        chk("out_ready", out_ready, !m_pending);
        chk("out_busy", out_busy, m_pending);
        chk("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            chk("out_result", out_result, m_res);
            chk("out_illegal", out_illegal, m_ill);
        end
        if (m_ctl_ok) begin
            chk("out_FPU_Op", out_FPU_Op, m_op);
            chk("out_fmt", out_fmt, m_fmt);
            chk("out_output_fmt", out_output_fmt, m_ofmt);
            chk("out_addsub_ctrl", out_addsub_ctrl, m_as);
            chk("out_ctrl", out_ctrl, m_ctrl);
            chk("out_fpu_rs1", out_fpu_rs1, m_rs1);
            chk("out_fpu_rs2", out_fpu_rs2, m_rs2);
        end
    endtask

    task automatic step(output bit acc);
        acc = in_valid && out_ready;
        @(posedge in_clk);
        model_edge();
        #1;
        compare();
    endtask

    // Presents one op, waits for acceptance, then counts edges until out_valid shows.
    task automatic run_op(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] r2,
                          input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] fres, output int lat);
        bit acc;
        acc = 0;
        in_funct7 = f7; in_funct3 = f3; in_rs2_sel = r2;
        in_rs1_data = a; in_rs2_data = b; in_fpu_result = fres;
        in_ready = 0; in_valid = 1;
        for (int i = 0; i < 40 && !acc; i++) step(acc);
        if (!acc) chk("accept_timeout", 0, 1);
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            step(acc);
            lat++;
        end
    endtask

    task automatic release_result();
        bit acc;
        in_ready = 1;
        step(acc);
        in_ready = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, out_ready, 1);
        chk({tag, "_busy"}, out_busy, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_op"}, out_FPU_Op, 4'hF);
        chk({tag, "_result"}, out_result, 0);
        chk({tag, "_illegal"}, out_illegal, 0);
        chk({tag, "_rs1"}, out_fpu_rs1, 0);
        chk({tag, "_ctrl"}, out_ctrl, 0);
        chk({tag, "_fmt"}, out_fmt, 0);
    endtask

    task automatic new_req();
        int k;
        logic [4:0] cls;
        logic [4:0] pool [9];
        pool = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd20, 5'd4, 5'd8, 5'd24};
        k = $urandom_range(0, 9);
        cls = (k < 9) ? pool[k] : 5'($urandom_range(0, 31));
        in_funct7 = {cls, ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1))};
        in_funct3 = 3'($urandom_range(0, 7));
        in_rs2_sel = 5'($urandom_range(0, 31));
        in_rs1_data = {$urandom, $urandom};
        in_rs2_data = {$urandom, $urandom};
    endtask

    initial begin
        int lat;
        bit acc, pend_req;
        in_rst_n = 0; in_valid = 0; in_ready = 0;
        in_funct7 = '0; in_funct3 = '0; in_rs2_sel = '0;
        in_rs1_data = '0; in_rs2_data = '0; in_fpu_result = '0;
        model_reset();
        #12;
        check_reset_outputs("rst_init");
        @(posedge in_clk);
        #1 in_rst_n = 1;

        // FADD.D 1.0 + 2.0
        run_op(7'b0000001, 3'b000, 5'd0, 64'h3FF0000000000000, 64'h4000000000000000,
               64'h4008000000000000, lat);
        chk("fadd_latency", lat, 2);
        chk("fadd_op", out_FPU_Op, 4'd0);
        chk("fadd_fmt", out_fmt, 1);
        chk("fadd_result", out_result, 64'h4008000000000000);
        release_result();

        // FDIV.D 6.0 / 2.0
        run_op(7'b0001101, 3'b000, 5'd0, 64'h4018000000000000, 64'h4000000000000000,
               64'h4008000000000000, lat);
        chk("fdiv_latency", lat, 8);
        chk("fdiv_op", out_FPU_Op, 4'd2);
        chk("fdiv_result", out_result, 64'h4008000000000000);
        chk("fdiv_ready_low", out_ready, 0);
        release_result();

        // FMUL.D held in DONE by backpressure while a new request waits
        run_op(7'b0001001, 3'b000, 5'd0, 64'h4000000000000000, 64'h4008000000000000,
               64'h4018000000000000, lat);
        in_funct7 = 7'b0000101; in_valid = 1; in_fpu_result = 64'h1234;
        for (int i = 0; i < 5; i++) begin
            step(acc);
            chk("bp_no_accept", acc, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_result", out_result, 64'h4018000000000000);
        end
        in_ready = 1;
        step(acc);
        chk("bp_release_no_accept", acc, 0);
        in_ready = 0;
        step(acc);
        chk("bp_accept_in_idle", acc, 1);
        in_valid = 0;
        for (int i = 0; i < 20 && !out_valid; i++) step(acc);
        chk("bp_fsub_done", out_valid, 1);
        release_result();

        // Illegal class
        run_op(7'b1111101, 3'b000, 5'd0, 64'h1, 64'h2, 64'hDEAD, lat);
        chk("ill_latency", lat, 0);
        chk("ill_flag", out_illegal, 1);
        chk("ill_result", out_result, 0);
        release_result();

        // FMAX.S
        run_op(7'b0010100, 3'b001, 5'd0, 64'h3F800000, 64'h40000000, 64'h40000000, lat);
        chk("fmax_latency", lat, FAST ? 1 : 2);
        chk("fmax_op", out_FPU_Op, 4'd3);
        chk("fmax_ctrl", out_ctrl, 3'b001);
        release_result();

        // Asynchronous reset in the middle of a divide
        in_funct7 = 7'b0001101; in_valid = 1;
        step(acc);
        chk("rst_div_accept", acc, 1);
        in_valid = 0;
        step(acc);
        step(acc);
        #3 in_rst_n = 0;
        #1 check_reset_outputs("rst_mid_exec");
        model_reset();
        @(posedge in_clk);
        #1 in_rst_n = 1;

        // Randomized traffic; a request is held until accepted
        pend_req = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend_req && $urandom_range(0, 2) != 0) begin
                new_req();
                pend_req = 1;
            end
            in_valid = pend_req;
            in_ready = ($urandom_range(0, 3) != 0);
            in_fpu_result = {$urandom, $urandom};
            step(acc);
            if (acc) pend_req = 0;
        end
        in_valid = 0;
        in_ready = 1;
        for (int i = 0; i < 20; i++) step(acc);
        chk("drain_idle", out_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
